// File: rtl/image_frame_arbiter.sv
// Two-stream frame arbiter. A stream holds the grant for a whole frame of
// FRAME_PIXELS tokens. A single output register passes tokens through at one
// token per cycle and absorbs downstream backpressure.
module image_frame_arbiter #(
    parameter int FRAME_PIXELS = 16,
    parameter int DATA_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              In0_SEND,
    input  logic [DATA_W-1:0] In0_DATA,
    input  logic [15:0]       In0_COUNT,
    output logic              In0_ACK,
    input  logic              In1_SEND,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic [15:0]       In1_COUNT,
    output logic              In1_ACK,
    output logic              Out1_SEND,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic [15:0]       Out1_COUNT,
    input  logic              Out1_RDY,
    input  logic              Out1_ACK,
    output logic [1:0]        GRANT,
    output logic              FRAME_DONE
);
    // One-hot encoding, so the state register drives GRANT directly
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GRANT0 = 2'b01;
    localparam logic [1:0] GRANT1 = 2'b10;

    logic [1:0]             state, state_nxt;
    logic                   buf_valid;
    logic [DATA_W-1:0]      buf_data;
    logic [15:0]            pix_cnt;
    logic                   last_owner;   // 0: stream 0 had the last frame
    logic [1:0]             send, ack;
    logic [1:0][DATA_W-1:0] data;
    logic                   out_xfer, in_xfer, in_sel, last_tok;
    logic [16:0]            cnt_inc;
    logic                   unused_counts;

    // Input token counts carry no meaning for arbitration
    assign unused_counts = ^{In0_COUNT, In1_COUNT};

    assign send = {In1_SEND, In0_SEND};
    assign data = {In1_DATA, In0_DATA};

    assign Out1_SEND  = buf_valid & Out1_RDY;
    assign Out1_DATA  = buf_data;
    assign Out1_COUNT = 16'h1;
    assign out_xfer   = Out1_SEND & Out1_ACK;
    assign GRANT      = state;

    // A granted stream is accepted when the buffer is empty or draining now
    for (genvar k = 0; k < 2; k++) begin : g_ack
        assign ack[k] = state[k] & send[k] & (~buf_valid | out_xfer);
    end
    assign In0_ACK = ack[0];
    assign In1_ACK = ack[1];

    assign in_xfer    = |ack;
    assign in_sel     = ack[1];
    assign cnt_inc    = {1'b0, pix_cnt} + 17'd1;
    assign last_tok   = in_xfer && (cnt_inc == 17'(FRAME_PIXELS));
    assign FRAME_DONE = last_tok;

    // Next-state: round-robin on contention, hold grant until frame end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (send == 2'b11)
                    state_nxt = last_owner ? GRANT0 : GRANT1;
                else if (send[0])
                    state_nxt = GRANT0;
                else if (send[1])
                    state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (last_tok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output buffer: load on accept, clear on drain, both at once keeps it full
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (in_xfer) begin
            buf_valid <= 1'b1;
            buf_data  <= data[in_sel];
        end else if (out_xfer) begin
            buf_valid <= 1'b0;
        end
    end

    // Frame pixel count and fairness history
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pix_cnt    <= '0;
            last_owner <= 1'b1;
        end else if (last_tok) begin
            pix_cnt    <= '0;
            last_owner <= in_sel;
        end else if (in_xfer) begin
            pix_cnt    <= cnt_inc[15:0];
        end
    end
endmodule

// File: tb/tb_image_frame_arbiter.sv
// Directed bench: vector tables for single-stream, backpressure and mid-frame
// gap cases; hand sequences for contention, async reset and FRAME_PIXELS=1.
module tb_image_frame_arbiter;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    // DUT A: FRAME_PIXELS = 4
    logic       s0 = 0, s1 = 0, rdy = 0, oack = 0;
    logic [7:0] d0 = 0, d1 = 0;
    logic       a0, a1, os, fd;
    logic [7:0] od;
    logic [15:0] ocnt;
    logic [1:0] g;
    // DUT B: FRAME_PIXELS = 1
    logic       bs0 = 0, bs1 = 0, brdy = 1, back = 1;
    logic [7:0] bd0 = 8'h70, bd1 = 8'hE0;
    logic       ba0, ba1, bos, bfd;
    logic [7:0] bod;
    logic [15:0] bcnt;
    logic [1:0] bg;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 CLK = ~CLK;

    image_frame_arbiter #(.FRAME_PIXELS(4), .DATA_W(8)) u_a (
        .CLK(CLK), .RESET(RESET),
        .In0_SEND(s0), .In0_DATA(d0), .In0_COUNT(16'h0), .In0_ACK(a0),
        .In1_SEND(s1), .In1_DATA(d1), .In1_COUNT(16'h0), .In1_ACK(a1),
        .Out1_SEND(os), .Out1_DATA(od), .Out1_COUNT(ocnt),
        .Out1_RDY(rdy), .Out1_ACK(oack), .GRANT(g), .FRAME_DONE(fd));

    image_frame_arbiter #(.FRAME_PIXELS(1), .DATA_W(8)) u_b (
        .CLK(CLK), .RESET(RESET),
        .In0_SEND(bs0), .In0_DATA(bd0), .In0_COUNT(16'h0), .In0_ACK(ba0),
        .In1_SEND(bs1), .In1_DATA(bd1), .In1_COUNT(16'h0), .In1_ACK(ba1),
        .Out1_SEND(bos), .Out1_DATA(bod), .Out1_COUNT(bcnt),
        .Out1_RDY(brdy), .Out1_ACK(back), .GRANT(bg), .FRAME_DONE(bfd));

    typedef struct {
        logic       rdy, s0, s1;
        logic [7:0] d0, d1;
        logic [1:0] g;
        logic       a0, a1, os;
        logic [7:0] od;
        logic       fd;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void pv(input logic r, input logic i0, input logic [7:0] x0,
                               input logic i1, input logic [7:0] x1, input logic [1:0] eg,
                               input logic e0, input logic e1, input logic eos,
                               input logic [7:0] eod, input logic efd);
        vec_t v;
        v.rdy = r; v.s0 = i0; v.d0 = x0; v.s1 = i1; v.d1 = x1; v.g = eg;
        v.a0 = e0; v.a1 = e1; v.os = eos; v.od = eod; v.fd = efd;
        vq.push_back(v);
    endfunction

    // Apply queued vectors one per cycle: drive after posedge, check at negedge
    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            rdy = vq[i].rdy; oack = 1'b1;
            s0 = vq[i].s0; d0 = vq[i].d0; s1 = vq[i].s1; d1 = vq[i].d1;
            @(negedge CLK);
            chk($sformatf("%s[%0d].grant", tag, i), g, vq[i].g);
            chk($sformatf("%s[%0d].ack0", tag, i), a0, vq[i].a0);
            chk($sformatf("%s[%0d].ack1", tag, i), a1, vq[i].a1);
            chk($sformatf("%s[%0d].osend", tag, i), os, vq[i].os);
            if (vq[i].os) chk($sformatf("%s[%0d].odata", tag, i), od, vq[i].od);
            chk($sformatf("%s[%0d].done", tag, i), fd, vq[i].fd);
            @(posedge CLK); #1;
        end
        vq.delete();
    endtask

    // Both streams send continuously; frames must alternate starting at 'first'
    task automatic run_cont(input string tag, input int ntok, input int first);
        int ntx = 0, n0 = 0, n1 = 0, cyc = 0;
        logic [7:0] exp_d;
        rdy = 1; oack = 1;
        while ((ntx < ntok || sb.size() > 0) && cyc < ntok * 4 + 20) begin
            s0 = (ntx < ntok); s1 = (ntx < ntok);
            d0 = 8'(n0); d1 = 8'h80 | 8'(n1);
            @(negedge CLK);
            if (a0 && a1) chk({tag, ".both_ack"}, 1, 0);
            if (os) begin
                if (sb.size() == 0) chk({tag, ".spurious_out"}, {24'h0, od}, 32'hFFFF);
                else begin
                    exp_d = sb.pop_front();
                    chk({tag, ".odata"}, od, exp_d);
                end
            end
            if (a0 || a1) begin
                chk($sformatf("%s.owner%0d", tag, ntx), a1, 32'(first ^ ((ntx / 4) % 2)));
                chk($sformatf("%s.grant%0d", tag, ntx), g, a1 ? 2'b10 : 2'b01);
                chk($sformatf("%s.done%0d", tag, ntx), fd, 32'((ntx % 4) == 3));
                sb.push_back(a1 ? d1 : d0);
                if (a1) n1++; else n0++;
                ntx++;
            end else begin
                chk({tag, ".done_idle"}, fd, 0);
            end
            @(posedge CLK); #1;
            cyc++;
        end
        chk({tag, ".timeout"}, 32'(ntx == ntok && sb.size() == 0), 1);
        s0 = 0; s1 = 0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.grant", g, 0);   chk("rst.osend", os, 0);
        chk("rst.ack0", a0, 0);   chk("rst.ack1", a1, 0);
        chk("rst.done", fd, 0);   chk("rst.count", ocnt, 16'h1);
        chk("rst.b_count", bcnt, 16'h1);
        @(posedge CLK); #3; RESET = 1;
        @(posedge CLK); #1;

        // Single stream, 10..13
        pv(1,1,8'd10,0,0, 2'b00,0,0,0,0,0);
        pv(1,1,8'd10,0,0, 2'b01,1,0,0,0,0);
        pv(1,1,8'd11,0,0, 2'b01,1,0,1,8'd10,0);
        pv(1,1,8'd12,0,0, 2'b01,1,0,1,8'd11,0);
        pv(1,1,8'd13,0,0, 2'b01,1,0,1,8'd12,1);
        pv(1,0,8'd0, 0,0, 2'b00,0,0,1,8'd13,0);
        pv(1,0,8'd0, 0,0, 2'b00,0,0,0,0,0);
        run_vecs("single");

        // Contention: last frame was stream 0, so stream 1 goes first
        run_cont("cont", 16, 1);

        // Backpressure: RDY low 5 cycles after first token (ACK held high)
        pv(1,1,8'd20,0,0, 2'b00,0,0,0,0,0);
        pv(1,1,8'd20,0,0, 2'b01,1,0,0,0,0);
        for (int i = 0; i < 5; i++) pv(0,1,8'd21,0,0, 2'b01,0,0,0,0,0);
        pv(1,1,8'd21,0,0, 2'b01,1,0,1,8'd20,0);
        pv(1,1,8'd22,0,0, 2'b01,1,0,1,8'd21,0);
        pv(1,1,8'd23,0,0, 2'b01,1,0,1,8'd22,1);
        pv(1,0,8'd0, 0,0, 2'b00,0,0,1,8'd23,0);
        pv(1,0,8'd0, 0,0, 2'b00,0,0,0,0,0);
        run_vecs("bp");

        // Mid-frame gap: stream 0 pauses after 2 tokens, stream 1 must wait
        pv(1,1,8'd30,0,8'd40, 2'b00,0,0,0,0,0);
        pv(1,1,8'd30,1,8'd40, 2'b01,1,0,0,0,0);
        pv(1,1,8'd31,1,8'd40, 2'b01,1,0,1,8'd30,0);
        pv(1,0,8'd0, 1,8'd40, 2'b01,0,0,1,8'd31,0);
        pv(1,0,8'd0, 1,8'd40, 2'b01,0,0,0,0,0);
        pv(1,1,8'd32,1,8'd40, 2'b01,1,0,0,0,0);
        pv(1,1,8'd33,1,8'd40, 2'b01,1,0,1,8'd32,1);
        pv(1,0,8'd0, 1,8'd40, 2'b00,0,0,1,8'd33,0);
        pv(1,0,8'd0, 1,8'd40, 2'b10,0,1,0,0,0);
        pv(1,0,8'd0, 1,8'd41, 2'b10,0,1,1,8'd40,0);
        pv(1,0,8'd0, 1,8'd42, 2'b10,0,1,1,8'd41,0);
        pv(1,0,8'd0, 1,8'd43, 2'b10,0,1,1,8'd42,1);
        pv(1,0,8'd0, 0,8'd0,  2'b00,0,0,1,8'd43,0);
        pv(1,0,8'd0, 0,8'd0,  2'b00,0,0,0,0,0);
        run_vecs("gap");

        // Async reset during token 3 of a stream-0 frame
        rdy = 1; oack = 1; s0 = 1; s1 = 1; d0 = 8'h50; d1 = 8'h60;
        @(posedge CLK); #1;
        @(posedge CLK); #1; d0 = 8'h51;
        @(posedge CLK); #1; d0 = 8'h52;
        #2;
        chk("pre_rst.ack0", a0, 1);
        chk("pre_rst.osend", os, 1);
        RESET = 0;
        #1;
        chk("mid_rst.osend", os, 0); chk("mid_rst.ack0", a0, 0);
        chk("mid_rst.ack1", a1, 0);  chk("mid_rst.grant", g, 0);
        chk("mid_rst.done", fd, 0);  chk("mid_rst.count", ocnt, 16'h1);
        @(posedge CLK);
        @(posedge CLK); #3;
        RESET = 1;
        sb.delete();
        run_cont("post_rst", 8, 0);

        // FRAME_PIXELS=1: grants alternate with a bubble, DONE on each transfer
        bs0 = 1; bs1 = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            chk($sformatf("fp1[%0d].grant", i), bg,
                (i % 4 == 1) ? 2'b01 : (i % 4 == 3) ? 2'b10 : 2'b00);
            chk($sformatf("fp1[%0d].ack0", i), ba0, 32'(i % 4 == 1));
            chk($sformatf("fp1[%0d].ack1", i), ba1, 32'(i % 4 == 3));
            chk($sformatf("fp1[%0d].done", i), bfd, 32'(i % 2 == 1));
            chk($sformatf("fp1[%0d].osend", i), bos, 32'(i > 0 && i % 2 == 0));
            if (i > 0 && i % 2 == 0)
                chk($sformatf("fp1[%0d].odata", i), bod, (i % 4 == 2) ? 8'h70 : 8'hE0);
            @(posedge CLK); #1;
        end
        bs0 = 0; bs1 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
